// File: rtl/minirisc_bus_arbiter.sv
// minirisc_bus_arbiter: two-master round-robin bus arbiter with registered one-hot grant and a dead cycle between owners
module minirisc_bus_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_bus_req,
  output logic       m0_bus_grant,
  input  logic [7:0] m0_mst2slv_addr,
  input  logic       m0_mst2slv_wr,
  input  logic       m0_mst2slv_rd,
  input  logic [7:0] m0_mst2slv_data,
  input  logic       m1_bus_req,
  output logic       m1_bus_grant,
  input  logic [7:0] m1_mst2slv_addr,
  input  logic       m1_mst2slv_wr,
  input  logic       m1_mst2slv_rd,
  input  logic [7:0] m1_mst2slv_data,
  output logic [7:0] s_mst2slv_addr,
  output logic       s_mst2slv_wr,
  output logic       s_mst2slv_rd,
  output logic [7:0] s_mst2slv_data,
  input  logic [7:0] s_slv2mst_data,
  output logic [7:0] m_slv2mst_data,
  output logic [1:0] bus_owner
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, next;
  logic   last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next;
      if (next == GNT0) last <= 1'b0;
      else if (next == GNT1) last <= 1'b1;
    end
  always_comb begin
    next = IDLE;
    next = (state == GNT0) ? (m0_bus_req ? GNT0 : IDLE) :
           (state == GNT1) ? (m1_bus_req ? GNT1 : IDLE) :
           (m0_bus_req && m1_bus_req) ? (last ? GNT0 : GNT1) :
           m0_bus_req ? GNT0 :
           m1_bus_req ? GNT1 : IDLE;
  end
  assign m0_bus_grant   = (state == GNT0);
  assign m1_bus_grant   = (state == GNT1);
  assign bus_owner      = {m1_bus_grant, m0_bus_grant};
  assign s_mst2slv_addr = m0_bus_grant ? m0_mst2slv_addr : m1_bus_grant ? m1_mst2slv_addr : 8'h00;
  assign s_mst2slv_wr   = m0_bus_grant ? m0_mst2slv_wr   : m1_bus_grant & m1_mst2slv_wr;
  assign s_mst2slv_rd   = m0_bus_grant ? m0_mst2slv_rd   : m1_bus_grant & m1_mst2slv_rd;
  assign s_mst2slv_data = m0_bus_grant ? m0_mst2slv_data : m1_bus_grant ? m1_mst2slv_data : 8'h00;
  assign m_slv2mst_data = s_slv2mst_data;
endmodule
